// File: rtl/ex_mem_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_reg_pkg
//  Description : Shared pipeline definitions for the EX/MEM boundary:
//                register-index and data widths, the R0 index and the packed
//                control bundle carried from EX into MEM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_reg_pkg;

   localparam int c_REG_W  = 4;
   localparam int c_DATA_W = 16;

   // R0 is hard-wired to zero, so it never acts as a forwarding source.
   localparam logic [c_REG_W-1:0] c_R0_IDX = '0;

   // Memory-stage control bundle.
   // ld_byte    : 1 = LLB (low byte), 0 = LHB (high byte)
   // is_byte_ld : instruction is an LLB/LHB
   typedef struct packed {
      logic mem_op;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
      logic ld_byte;
      logic is_byte_ld;
   } ex_mem_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ex_mem_reg_fwd_detect.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_detect
//  Description : Combinational forwarding-select logic for the EX/MEM
//                register.
//                fwd_imm   - EX byte-load targets the same register as the
//                            byte-load currently in MEM (LHB/LLB pair), so the
//                            memory stage must merge with the in-flight value.
//                fwd_store - store data in EX is being written back this
//                            cycle; take it from the writeback port.
//  Ports       : EX-side byte-load/store info, MEM-side registered state,
//                writeback port; outputs fwd_imm, fwd_store.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_detect
   import ex_mem_reg_pkg::*;
(
   input  logic               is_byte_ld_ex,
   input  logic [c_REG_W-1:0] rd_ex,
   input  logic               valid_mem,
   input  logic               is_byte_ld_mem,
   input  logic               reg_write_mem,
   input  logic [c_REG_W-1:0] rd_mem,
   input  logic               mem_write_ex,
   input  logic [c_REG_W-1:0] rt_ex,
   input  logic               wb_reg_write,
   input  logic [c_REG_W-1:0] wb_rd,
   output logic               fwd_imm,
   output logic               fwd_store
);

   assign fwd_imm = is_byte_ld_ex && valid_mem && is_byte_ld_mem &&
                    reg_write_mem && (rd_mem == rd_ex) && (rd_ex != c_R0_IDX);

   assign fwd_store = mem_write_ex && wb_reg_write &&
                      (wb_rd == rt_ex) && (rt_ex != c_R0_IDX);

endmodule
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_reg
//  Description : EX/MEM pipeline register with stall, flush/bubble insertion,
//                sticky halt, byte-load immediate forwarding flag and
//                store-data forwarding from writeback.
//  Ports       : clk, rst (async active-low), stall, flush,
//                EX inputs (*_ex), writeback port (wb_*),
//                MEM outputs (alu_out, RegData2, imm_MEM, MemOp, MemWrite,
//                ForwardImm, LdByte, reg_write_mem, mem_to_reg_mem,
//                is_byte_ld_mem, valid_mem, rd_mem), halted.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg
   import ex_mem_reg_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic                valid_ex,
   input  logic [c_DATA_W-1:0] alu_out_ex,
   input  logic [c_DATA_W-1:0] reg_data2_ex,
   input  logic [c_DATA_W-1:0] imm_ex,
   input  logic [c_REG_W-1:0]  rd_ex,
   input  logic [c_REG_W-1:0]  rt_ex,
   input  logic                mem_op_ex,
   input  logic                mem_write_ex,
   input  logic                reg_write_ex,
   input  logic                mem_to_reg_ex,
   input  logic                ld_byte_ex,
   input  logic                is_byte_ld_ex,
   input  logic                halt_ex,
   input  logic                wb_reg_write,
   input  logic [c_REG_W-1:0]  wb_rd,
   input  logic [c_DATA_W-1:0] wb_data,
   output logic [c_DATA_W-1:0] alu_out,
   output logic [c_DATA_W-1:0] RegData2,
   output logic [c_DATA_W-1:0] imm_MEM,
   output logic                MemOp,
   output logic                MemWrite,
   output logic                ForwardImm,
   output logic                LdByte,
   output logic                reg_write_mem,
   output logic                mem_to_reg_mem,
   output logic                is_byte_ld_mem,
   output logic                valid_mem,
   output logic [c_REG_W-1:0]  rd_mem,
   output logic                halted
);

   logic [c_DATA_W-1:0] r_alu_out;
   logic [c_DATA_W-1:0] r_reg_data2;
   logic [c_DATA_W-1:0] r_imm;
   logic [c_REG_W-1:0]  r_rd;
   ex_mem_ctrl_t        r_ctrl;
   logic                r_fwd_imm;
   logic                r_valid;
   logic                r_halted;

   ex_mem_ctrl_t        w_ctrl_ex;
   logic                w_capture;
   logic                w_fwd_imm;
   logic                w_fwd_store;

   assign w_ctrl_ex = '{mem_op:     mem_op_ex,
                        mem_write:  mem_write_ex,
                        reg_write:  reg_write_ex,
                        mem_to_reg: mem_to_reg_ex,
                        ld_byte:    ld_byte_ex,
                        is_byte_ld: is_byte_ld_ex};

   // A real instruction is taken only if it is not being flushed and the
   // machine has not already halted; anything else becomes a bubble.
   assign w_capture = valid_ex && !flush && !r_halted;

   fwd_detect u_fwd_detect (
      .is_byte_ld_ex  (is_byte_ld_ex),
      .rd_ex          (rd_ex),
      .valid_mem      (r_valid),
      .is_byte_ld_mem (r_ctrl.is_byte_ld),
      .reg_write_mem  (r_ctrl.reg_write),
      .rd_mem         (r_rd),
      .mem_write_ex   (mem_write_ex),
      .rt_ex          (rt_ex),
      .wb_reg_write   (wb_reg_write),
      .wb_rd          (wb_rd),
      .fwd_imm        (w_fwd_imm),
      .fwd_store      (w_fwd_store)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_alu_out   <= '0;
         r_reg_data2 <= '0;
         r_imm       <= '0;
         r_rd        <= '0;
         r_ctrl      <= '0;
         r_fwd_imm   <= 1'b0;
         r_valid     <= 1'b0;
         r_halted    <= 1'b0;
      end else if (!stall) begin
         if (w_capture) begin
            r_alu_out   <= alu_out_ex;
            r_reg_data2 <= w_fwd_store ? wb_data : reg_data2_ex;
            r_imm       <= imm_ex;
            r_rd        <= rd_ex;
            r_ctrl      <= w_ctrl_ex;
            r_fwd_imm   <= w_fwd_imm;
            r_valid     <= 1'b1;
            if (halt_ex) begin
               r_halted <= 1'b1;
            end
         end else begin
            // Bubble: kill every state-changing control, keep data fields.
            r_ctrl.mem_op     <= 1'b0;
            r_ctrl.mem_write  <= 1'b0;
            r_ctrl.reg_write  <= 1'b0;
            r_ctrl.is_byte_ld <= 1'b0;
            r_fwd_imm         <= 1'b0;
            r_valid           <= 1'b0;
         end
      end
   end

   assign alu_out        = r_alu_out;
   assign RegData2       = r_reg_data2;
   assign imm_MEM        = r_imm;
   assign rd_mem         = r_rd;
   assign MemOp          = r_ctrl.mem_op;
   assign MemWrite       = r_ctrl.mem_write;
   assign reg_write_mem  = r_ctrl.reg_write;
   assign mem_to_reg_mem = r_ctrl.mem_to_reg;
   assign LdByte         = r_ctrl.ld_byte;
   assign is_byte_ld_mem = r_ctrl.is_byte_ld;
   assign ForwardImm     = r_fwd_imm;
   assign valid_mem      = r_valid;
   assign halted         = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_reg
//  Description : Self-checking bench for ex_mem_reg. A reference model
//                predicts the MEM-side state for every driven cycle; the
//                prediction is queued and compared after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, valid_ex;
   logic [15:0] alu_out_ex, reg_data2_ex, imm_ex, wb_data;
   logic [3:0]  rd_ex, rt_ex, wb_rd;
   logic        mem_op_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex;
   logic        ld_byte_ex, is_byte_ld_ex, halt_ex, wb_reg_write;

   logic [15:0] alu_out, RegData2, imm_MEM;
   logic        MemOp, MemWrite, ForwardImm, LdByte;
   logic        reg_write_mem, mem_to_reg_mem, is_byte_ld_mem, valid_mem;
   logic [3:0]  rd_mem;
   logic        halted;

   typedef struct {
      logic [15:0] alu;
      logic [15:0] d2;
      logic [15:0] imm;
      logic        mem_op;
      logic        mem_write;
      logic        fwd_imm;
      logic        ld_byte;
      logic        reg_write;
      logic        mem_to_reg;
      logic        is_byte_ld;
      logic        valid;
      logic [3:0]  rd;
      logic        halted;
   } exp_t;

   exp_t m;
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   ex_mem_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_ex(valid_ex),
      .alu_out_ex(alu_out_ex), .reg_data2_ex(reg_data2_ex), .imm_ex(imm_ex),
      .rd_ex(rd_ex), .rt_ex(rt_ex), .mem_op_ex(mem_op_ex),
      .mem_write_ex(mem_write_ex), .reg_write_ex(reg_write_ex),
      .mem_to_reg_ex(mem_to_reg_ex), .ld_byte_ex(ld_byte_ex),
      .is_byte_ld_ex(is_byte_ld_ex), .halt_ex(halt_ex),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .alu_out(alu_out), .RegData2(RegData2), .imm_MEM(imm_MEM),
      .MemOp(MemOp), .MemWrite(MemWrite), .ForwardImm(ForwardImm),
      .LdByte(LdByte), .reg_write_mem(reg_write_mem),
      .mem_to_reg_mem(mem_to_reg_mem), .is_byte_ld_mem(is_byte_ld_mem),
      .valid_mem(valid_mem), .rd_mem(rd_mem), .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_state(input string tag, input exp_t e);
      check_eq({tag, ".alu_out"},    alu_out,                e.alu);
      check_eq({tag, ".RegData2"},   RegData2,               e.d2);
      check_eq({tag, ".imm_MEM"},    imm_MEM,                e.imm);
      check_eq({tag, ".MemOp"},      16'(MemOp),             16'(e.mem_op));
      check_eq({tag, ".MemWrite"},   16'(MemWrite),          16'(e.mem_write));
      check_eq({tag, ".ForwardImm"}, 16'(ForwardImm),        16'(e.fwd_imm));
      check_eq({tag, ".LdByte"},     16'(LdByte),            16'(e.ld_byte));
      check_eq({tag, ".reg_write"},  16'(reg_write_mem),     16'(e.reg_write));
      check_eq({tag, ".mem_to_reg"}, 16'(mem_to_reg_mem),    16'(e.mem_to_reg));
      check_eq({tag, ".is_byte_ld"}, 16'(is_byte_ld_mem),    16'(e.is_byte_ld));
      check_eq({tag, ".valid_mem"},  16'(valid_mem),         16'(e.valid));
      check_eq({tag, ".rd_mem"},     16'(rd_mem),            16'(e.rd));
      check_eq({tag, ".halted"},     16'(halted),            16'(e.halted));
   endtask

   // Reference model: next MEM-side state from current state and EX inputs.
   task automatic model_step(output exp_t nx);
      logic take;
      nx = m;
      if (!stall) begin
         take = valid_ex && !flush && !m.halted;
         if (take) begin
            nx.alu        = alu_out_ex;
            nx.d2         = (mem_write_ex && wb_reg_write && wb_rd == rt_ex &&
                             rt_ex != 4'd0) ? wb_data : reg_data2_ex;
            nx.imm        = imm_ex;
            nx.rd         = rd_ex;
            nx.mem_op     = mem_op_ex;
            nx.mem_write  = mem_write_ex;
            nx.reg_write  = reg_write_ex;
            nx.mem_to_reg = mem_to_reg_ex;
            nx.ld_byte    = ld_byte_ex;
            nx.is_byte_ld = is_byte_ld_ex;
            nx.fwd_imm    = is_byte_ld_ex && m.valid && m.is_byte_ld &&
                            m.reg_write && (m.rd == rd_ex) && (rd_ex != 4'd0);
            nx.valid      = 1'b1;
            nx.halted     = m.halted | halt_ex;
         end else begin
            nx.valid      = 1'b0;
            nx.mem_op     = 1'b0;
            nx.mem_write  = 1'b0;
            nx.reg_write  = 1'b0;
            nx.is_byte_ld = 1'b0;
            nx.fwd_imm    = 1'b0;
         end
      end
   endtask

   // Drive one clock: predict, queue, clock, then pop and compare.
   task automatic cycle(input string tag);
      exp_t nx;
      exp_t e;
      model_step(nx);
      exp_q.push_back(nx);
      m = nx;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq({tag, ".queue_empty"}, 16'd0, 16'd1);
      end else begin
         e = exp_q.pop_front();
         compare_state(tag, e);
      end
   endtask

   task automatic set_nop();
      stall = 0; flush = 0; valid_ex = 0;
      mem_op_ex = 0; mem_write_ex = 0; reg_write_ex = 0; mem_to_reg_ex = 0;
      ld_byte_ex = 0; is_byte_ld_ex = 0; halt_ex = 0; wb_reg_write = 0;
      rd_ex = 0; rt_ex = 0; wb_rd = 0;
      alu_out_ex = 16'h0; reg_data2_ex = 16'h0; imm_ex = 16'h0; wb_data = 16'h0;
   endtask

   // Async reset pulse starting mid-cycle; leaves time at posedge+1.
   task automatic reset_pulse(input string tag);
      exp_t z;
      z = '{default: '0};
      #2 rst = 1'b0;
      #1 compare_state({tag, "_async"}, z);
      @(posedge clk);
      #1 compare_state({tag, "_held"}, z);
      rst = 1'b1;
      m = z;
   endtask

   initial begin
      // Nonzero inputs during reset to show the clear does not depend on them.
      stall = 0; flush = 0; valid_ex = 1; rst = 1;
      alu_out_ex = 16'h1234; reg_data2_ex = 16'h5678; imm_ex = 16'h9ABC;
      rd_ex = 4'h3; rt_ex = 4'h5; mem_op_ex = 1; mem_write_ex = 1;
      reg_write_ex = 1; mem_to_reg_ex = 1; ld_byte_ex = 1; is_byte_ld_ex = 1;
      halt_ex = 0; wb_reg_write = 1; wb_rd = 4'h5; wb_data = 16'hFFFF;
      @(posedge clk);
      #1;
      reset_pulse("reset");

      // Plain ALU op: 1-cycle latency.
      set_nop(); valid_ex = 1; alu_out_ex = 16'hA5A5; reg_write_ex = 1;
      rd_ex = 4'd7; imm_ex = 16'h0011;
      cycle("alu");
      check_eq("alu_latency", alu_out, 16'hA5A5);

      // LHB R3 then LLB R3 -> ForwardImm.
      set_nop(); valid_ex = 1; is_byte_ld_ex = 1; ld_byte_ex = 0;
      reg_write_ex = 1; rd_ex = 4'd3; imm_ex = 16'h00AB;
      cycle("lhb_r3");
      ld_byte_ex = 1; imm_ex = 16'h00CD;
      cycle("llb_r3");
      check_eq("llb_r3_fwdimm", 16'(ForwardImm), 16'd1);
      check_eq("llb_r3_ldbyte", 16'(LdByte), 16'd1);

      // Same pair on R0 -> no forwarding.
      ld_byte_ex = 0; rd_ex = 4'd0; imm_ex = 16'h0012;
      cycle("lhb_r0");
      ld_byte_ex = 1; imm_ex = 16'h0034;
      cycle("llb_r0");
      check_eq("llb_r0_fwdimm", 16'(ForwardImm), 16'd0);

      // Store-data forwarding from writeback.
      set_nop(); valid_ex = 1; mem_op_ex = 1; mem_write_ex = 1; rt_ex = 4'd5;
      reg_data2_ex = 16'h1111; wb_reg_write = 1; wb_rd = 4'd5; wb_data = 16'hBEEF;
      cycle("sw_fwd");
      check_eq("sw_fwd_data", RegData2, 16'hBEEF);
      wb_rd = 4'd6;
      cycle("sw_nofwd");
      check_eq("sw_nofwd_data", RegData2, 16'h1111);
      rt_ex = 4'd0; wb_rd = 4'd0;
      cycle("sw_r0");
      check_eq("sw_r0_data", RegData2, 16'h1111);

      // Load, then stall with changing inputs, stall+flush, flush alone.
      set_nop(); valid_ex = 1; mem_op_ex = 1; mem_to_reg_ex = 1; reg_write_ex = 1;
      rd_ex = 4'd2; alu_out_ex = 16'h0040;
      cycle("load");
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         alu_out_ex = 16'($urandom); rd_ex = 4'(i + 8); imm_ex = 16'($urandom);
         cycle("stall");
      end
      check_eq("stall_alu_held", alu_out, 16'h0040);
      flush = 1;
      cycle("stall_flush");
      check_eq("stall_flush_valid", 16'(valid_mem), 16'd1);
      stall = 0;
      cycle("flush");
      check_eq("flush_valid", 16'(valid_mem), 16'd0);
      check_eq("flush_memop", 16'(MemOp), 16'd0);

      // valid_ex=0 is a bubble as well.
      set_nop(); mem_op_ex = 1; mem_write_ex = 1; reg_write_ex = 1;
      cycle("invalid_ex");

      // Randomised traffic with halt held off.
      for (int i = 0; i < 48; i++) begin
         stall         = ($urandom_range(0, 4) == 0);
         flush         = ($urandom_range(0, 4) == 0);
         valid_ex      = ($urandom_range(0, 4) != 0);
         alu_out_ex    = 16'($urandom);
         reg_data2_ex  = 16'($urandom);
         imm_ex        = 16'($urandom);
         wb_data       = 16'($urandom);
         rd_ex         = 4'($urandom_range(0, 3));
         rt_ex         = 4'($urandom_range(0, 3));
         wb_rd         = 4'($urandom_range(0, 3));
         mem_op_ex     = 1'($urandom);
         mem_write_ex  = 1'($urandom);
         reg_write_ex  = 1'($urandom);
         mem_to_reg_ex = 1'($urandom);
         ld_byte_ex    = 1'($urandom);
         is_byte_ld_ex = 1'($urandom);
         wb_reg_write  = 1'($urandom);
         halt_ex       = 1'b0;
         cycle("rand");
      end

      // Halt together with flush: flush wins.
      set_nop(); valid_ex = 1; halt_ex = 1; flush = 1;
      cycle("halt_flush");
      check_eq("halt_flush_halted", 16'(halted), 16'd0);
      check_eq("halt_flush_valid", 16'(valid_mem), 16'd0);

      // Reset during a stall clears everything; next edge captures normally.
      set_nop(); valid_ex = 1; mem_op_ex = 1; alu_out_ex = 16'h2222;
      cycle("pre_stall_rst");
      stall = 1;
      reset_pulse("rst_in_stall");
      set_nop(); valid_ex = 1; alu_out_ex = 16'h7777; rd_ex = 4'd9;
      reg_write_ex = 1;
      cycle("post_rst_capture");
      check_eq("post_rst_alu", alu_out, 16'h7777);

      // Halt reaches MEM, later instructions become bubbles.
      set_nop(); valid_ex = 1; halt_ex = 1; alu_out_ex = 16'h00AA;
      cycle("halt");
      check_eq("halt_set", 16'(halted), 16'd1);
      set_nop(); valid_ex = 1; mem_op_ex = 1; mem_write_ex = 1;
      reg_data2_ex = 16'h3333; rt_ex = 4'd4;
      cycle("halt_store");
      check_eq("halt_store_memwrite", 16'(MemWrite), 16'd0);
      cycle("halt_store2");
      check_eq("halt_sticky", 16'(halted), 16'd1);
      reset_pulse("halt_rst");
      check_eq("halt_cleared", 16'(halted), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
